// File: rtl/tl_ul_master.sv
// TileLink-UL initiator: converts cache load/store/refill requests into channel-A
// Get/Put messages, one outstanding beat at a time, and returns channel-D results.
module tl_ul_master #(
    parameter logic [4:0] SOURCE_ID  = 5'd0,
    parameter int         LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_burst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        busy,
    input  logic        Bus_aBitsReady,
    output logic        Bus_aBitsValid,
    output logic [31:0] Bus_aBitsAddress,
    output logic [2:0]  Bus_aBitsOpcode,
    output logic [3:0]  Bus_aBitsSize,
    output logic [3:0]  Bus_aBitsMask,
    output logic [31:0] Bus_aBitsData,
    output logic [2:0]  Bus_aBitsParam,
    output logic [4:0]  Bus_aBitsSource,
    output logic        Bus_aBitsCorrupt,
    output logic        Bus_dBitsReady,
    input  logic        Bus_dBitsValid,
    input  logic [2:0]  Bus_dBitsOpcode,
    input  logic [31:0] Bus_dBitsData,
    input  logic [1:0]  Bus_dBitsParam,
    input  logic [4:0]  Bus_dBitsSource,
    input  logic [1:0]  Bus_dBitsSink,
    input  logic        Bus_dBitsDennied,
    input  logic        Bus_dBitsCorrupt,
    input  logic [3:0]  Bus_dBitsSize
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT} state_t;

    state_t state, state_next;

    logic [31:0]      a_address;
    logic [2:0]       a_opcode;
    logic [3:0]       a_size;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic [4:0]       a_source;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_total;

    logic a_fire;
    logic d_fire;
    logic is_get;
    logic d_err;
    logic beat_last;
    logic unused_inputs;

    assign unused_inputs = ^{Bus_dBitsParam, Bus_dBitsSink, Bus_dBitsSize, req_addr[1:0]};

    assign a_fire    = (state == A_SEND) && Bus_aBitsReady;
    assign d_fire    = (state == D_WAIT) && Bus_dBitsValid;
    assign is_get    = (a_opcode == 3'd4);
    assign d_err     = Bus_dBitsDennied | Bus_dBitsCorrupt
                     | (Bus_dBitsOpcode != (is_get ? 3'd1 : 3'd0))
                     | (Bus_dBitsSource != SOURCE_ID);
    // An errored beat terminates the transaction, aborting any remaining refill beats.
    assign beat_last = d_err || ((beat_cnt + CNT_W'(1)) == beat_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = A_SEND;
            A_SEND:  if (a_fire)    state_next = D_WAIT;
            D_WAIT:  if (d_fire)    state_next = beat_last ? IDLE : A_SEND;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        busy           = 1'b1;
        Bus_aBitsValid = 1'b0;
        Bus_dBitsReady = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            A_SEND:  Bus_aBitsValid = 1'b1;
            D_WAIT:  Bus_dBitsReady = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Request latch, refill address walk and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_address  <= 32'd0;
            a_opcode   <= 3'd0;
            a_size     <= 4'd0;
            a_mask     <= 4'd0;
            a_data     <= 32'd0;
            a_source   <= 5'd0;
            beat_cnt   <= '0;
            beat_total <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= d_fire;
            rsp_last  <= d_fire && beat_last;
            rsp_err   <= d_fire && d_err;
            rsp_data  <= (d_fire && is_get) ? Bus_dBitsData : 32'd0;

            if (state == IDLE && req_valid) begin
                a_address  <= {req_addr[31:2], 2'b00};
                a_size     <= 4'd2;
                a_source   <= SOURCE_ID;
                beat_cnt   <= '0;
                beat_total <= (req_burst && !req_we) ? CNT_W'(LINE_WORDS) : CNT_W'(1);
                if (req_we) begin
                    a_opcode <= (req_mask == 4'hF) ? 3'd0 : 3'd1;
                    a_mask   <= req_mask;
                    a_data   <= req_wdata;
                end else begin
                    a_opcode <= 3'd4;
                    a_mask   <= 4'hF;
                    a_data   <= 32'd0;
                end
            end

            // Only the word index wraps, giving critical-word-first order inside the line.
            if (d_fire && !beat_last) begin
                beat_cnt                <= beat_cnt + CNT_W'(1);
                a_address[IDX_W+1:2]    <= a_address[IDX_W+1:2] + IDX_W'(1);
            end
        end
    end

    assign Bus_aBitsAddress = a_address;
    assign Bus_aBitsOpcode  = a_opcode;
    assign Bus_aBitsSize    = a_size;
    assign Bus_aBitsMask    = a_mask;
    assign Bus_aBitsData    = a_data;
    assign Bus_aBitsParam   = 3'd0;
    assign Bus_aBitsSource  = a_source;
    assign Bus_aBitsCorrupt = 1'b0;

endmodule

// File: tb/tb_tl_ul_master.sv
// Bench for tl_ul_master: acts as the TileLink responder, predicts every A beat and
// every response into queues and checks them as the DUT produces them.
module tb_tl_ul_master;

    localparam int         LW  = 4;
    localparam logic [4:0] SRC = 5'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_burst;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_valid, rsp_last, rsp_err, busy;
    logic [31:0] rsp_data;
    logic        Bus_aBitsReady, Bus_aBitsValid, Bus_aBitsCorrupt;
    logic [31:0] Bus_aBitsAddress, Bus_aBitsData;
    logic [2:0]  Bus_aBitsOpcode, Bus_aBitsParam;
    logic [3:0]  Bus_aBitsSize, Bus_aBitsMask;
    logic [4:0]  Bus_aBitsSource;
    logic        Bus_dBitsReady, Bus_dBitsValid, Bus_dBitsDennied, Bus_dBitsCorrupt;
    logic [2:0]  Bus_dBitsOpcode;
    logic [31:0] Bus_dBitsData;
    logic [1:0]  Bus_dBitsParam, Bus_dBitsSink;
    logic [4:0]  Bus_dBitsSource;
    logic [3:0]  Bus_dBitsSize;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  opcode;
        logic [3:0]  mask;
        logic [31:0] data;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_exp_t;

    a_exp_t   aQ[$];
    rsp_exp_t rspQ[$];
    rsp_exp_t monR;
    int       assertCount = 0;
    int       failCount   = 0;

    tl_ul_master #(.SOURCE_ID(SRC), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_burst(req_burst),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .busy(busy),
        .Bus_aBitsReady(Bus_aBitsReady), .Bus_aBitsValid(Bus_aBitsValid),
        .Bus_aBitsAddress(Bus_aBitsAddress), .Bus_aBitsOpcode(Bus_aBitsOpcode),
        .Bus_aBitsSize(Bus_aBitsSize), .Bus_aBitsMask(Bus_aBitsMask),
        .Bus_aBitsData(Bus_aBitsData), .Bus_aBitsParam(Bus_aBitsParam),
        .Bus_aBitsSource(Bus_aBitsSource), .Bus_aBitsCorrupt(Bus_aBitsCorrupt),
        .Bus_dBitsReady(Bus_dBitsReady), .Bus_dBitsValid(Bus_dBitsValid),
        .Bus_dBitsOpcode(Bus_dBitsOpcode), .Bus_dBitsData(Bus_dBitsData),
        .Bus_dBitsParam(Bus_dBitsParam), .Bus_dBitsSource(Bus_dBitsSource),
        .Bus_dBitsSink(Bus_dBitsSink), .Bus_dBitsDennied(Bus_dBitsDennied),
        .Bus_dBitsCorrupt(Bus_dBitsCorrupt), .Bus_dBitsSize(Bus_dBitsSize)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_a_valid", Bus_aBitsValid, 0);
        checkOutput("rst_d_ready", Bus_dBitsReady, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_last", rsp_last, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_a_addr", Bus_aBitsAddress, 0);
        checkOutput("rst_a_opcode", Bus_aBitsOpcode, 0);
        checkOutput("rst_a_mask", Bus_aBitsMask, 0);
        checkOutput("rst_a_data", Bus_aBitsData, 0);
        checkOutput("rst_a_source", Bus_aBitsSource, 0);
        checkOutput("rst_a_size", Bus_aBitsSize, 0);
    endtask

    task automatic applyStimulus(input logic we, input logic burst, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask);
        a_exp_t      e;
        int          n;
        int          start;
        logic [31:0] base;
        @(negedge clk);
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_burst = burst;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        n     = (burst && !we) ? LW : 1;
        base  = addr & ~32'(LW * 4 - 1);
        start = int'(addr[3:2]);
        for (int k = 0; k < n; k++) begin
            e.addr   = base | 32'(((start + k) % LW) * 4);
            e.opcode = !we ? 3'd4 : ((mask == 4'hF) ? 3'd0 : 3'd1);
            e.mask   = we ? mask : 4'hF;
            e.data   = we ? wdata : 32'd0;
            aQ.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("a_valid_latency", Bus_aBitsValid, 1);
        checkOutput("busy_active", busy, 1);
        checkOutput("req_ready_busy", req_ready, 0);
    endtask

    task automatic checkAFields(input a_exp_t e);
        checkOutput("a_valid", Bus_aBitsValid, 1);
        checkOutput("a_addr", Bus_aBitsAddress, e.addr);
        checkOutput("a_opcode", Bus_aBitsOpcode, 32'(e.opcode));
        checkOutput("a_size", Bus_aBitsSize, 2);
        checkOutput("a_mask", Bus_aBitsMask, 32'(e.mask));
        checkOutput("a_data", Bus_aBitsData, e.data);
        checkOutput("a_param", Bus_aBitsParam, 0);
        checkOutput("a_source", Bus_aBitsSource, 32'(SRC));
        checkOutput("a_corrupt", Bus_aBitsCorrupt, 0);
        checkOutput("d_ready_in_a", Bus_dBitsReady, 0);
    endtask

    // Responder for one beat: optional A backpressure (with stray D beats offered), D delay.
    task automatic serveBeat(input int aDelay, input int dDelay, input logic earlyD,
                             input logic [2:0] dOp, input logic [31:0] dData,
                             input logic denied, input logic corrupt, input logic [4:0] dSrc,
                             input logic isLast, input logic stopAfterA);
        a_exp_t   e;
        rsp_exp_t r;
        int       waitCnt = 0;
        logic     isGet;
        logic     err;
        while (!Bus_aBitsValid && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!Bus_aBitsValid) begin
            checkOutput("a_valid_timeout", 0, 1);
            return;
        end
        if (aQ.size() == 0) begin
            checkOutput("a_unexpected", 1, 0);
            return;
        end
        e = aQ.pop_front();
        for (int i = 0; i <= aDelay; i++) begin
            checkAFields(e);
            if (i < aDelay) begin
                Bus_dBitsValid  = earlyD;
                Bus_dBitsOpcode = dOp;
                Bus_dBitsSource = SRC;
                @(negedge clk);
            end
        end
        Bus_dBitsValid = 1'b0;
        Bus_aBitsReady = 1'b1;
        @(negedge clk);
        Bus_aBitsReady = 1'b0;
        checkOutput("a_valid_after_hs", Bus_aBitsValid, 0);
        checkOutput("d_ready_latency", Bus_dBitsReady, 1);
        if (stopAfterA) return;
        for (int i = 0; i < dDelay; i++) begin
            @(negedge clk);
            checkOutput("d_ready_hold", Bus_dBitsReady, 1);
        end
        isGet = (e.opcode == 3'd4);
        err   = denied | corrupt | (dOp != (isGet ? 3'd1 : 3'd0)) | (dSrc != SRC);
        Bus_dBitsValid   = 1'b1;
        Bus_dBitsOpcode  = dOp;
        Bus_dBitsData    = dData;
        Bus_dBitsDennied = denied;
        Bus_dBitsCorrupt = corrupt;
        Bus_dBitsSource  = dSrc;
        r.data = isGet ? dData : 32'd0;
        r.last = err | isLast;
        r.err  = err;
        rspQ.push_back(r);
        @(negedge clk);
        Bus_dBitsValid   = 1'b0;
        Bus_dBitsDennied = 1'b0;
        Bus_dBitsCorrupt = 1'b0;
        Bus_dBitsSource  = SRC;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest predicted response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rspQ.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                monR = rspQ.pop_front();
                checkOutput("rsp_data", rsp_data, monR.data);
                checkOutput("rsp_last", rsp_last, 32'(monR.last));
                checkOutput("rsp_err", rsp_err, 32'(monR.err));
                if (monR.last) checkOutput("req_ready_on_last", req_ready, 1);
                else           checkOutput("a_valid_next_beat", Bus_aBitsValid, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_mask = 4'd0;
        Bus_aBitsReady = 1'b0; Bus_dBitsValid = 1'b0; Bus_dBitsOpcode = 3'd0;
        Bus_dBitsData = 32'd0; Bus_dBitsParam = 2'd0; Bus_dBitsSource = SRC;
        Bus_dBitsSink = 2'd0; Bus_dBitsDennied = 1'b0; Bus_dBitsCorrupt = 1'b0;
        Bus_dBitsSize = 4'd2;
        #12;
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single load");
        applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, SRC, 1'b1, 1'b0);

        $display("[TB] wrapping refill");
        applyStimulus(1'b0, 1'b1, 32'h0000_0208, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'hA000_0208, 1'b0, 1'b0, SRC, 1'b0, 1'b0);
        serveBeat(1, 2, 1'b0, 3'd1, 32'hA000_020C, 1'b0, 1'b0, SRC, 1'b0, 1'b0);
        serveBeat(0, 1, 1'b0, 3'd1, 32'hA000_0200, 1'b0, 1'b0, SRC, 1'b0, 1'b0);
        serveBeat(2, 0, 1'b0, 3'd1, 32'hA000_0204, 1'b0, 1'b0, SRC, 1'b1, 1'b0);

        $display("[TB] partial and full stores");
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 4'h3);
        serveBeat(0, 0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, SRC, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'hF);
        serveBeat(0, 0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, SRC, 1'b1, 1'b0);

        $display("[TB] backpressure with stray D beats");
        applyStimulus(1'b0, 1'b0, 32'h0000_0050, 32'd0, 4'h0);
        serveBeat(5, 3, 1'b1, 3'd1, 32'h5555_AAAA, 1'b0, 1'b0, SRC, 1'b1, 1'b0);

        $display("[TB] refill aborted by denied beat");
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h0000_0300, 1'b0, 1'b0, SRC, 1'b0, 1'b0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h0000_0304, 1'b1, 1'b0, SRC, 1'b0, 1'b0);
        aQ.delete();
        for (int i = 0; i < 3; i++) begin
            checkOutput("no_beat_after_err", Bus_aBitsValid, 0);
            checkOutput("idle_after_err", req_ready, 1);
            @(negedge clk);
        end

        $display("[TB] error sources");
        applyStimulus(1'b0, 1'b0, 32'h0000_0107, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h1111_2222, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0060, 32'h0BAD_0BAD, 4'hC);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h3333_4444, 1'b0, 1'b0, SRC, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0070, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h7777_0000, 1'b0, 1'b1, SRC, 1'b1, 1'b0);

        $display("[TB] reset during D wait");
        applyStimulus(1'b0, 1'b0, 32'h0000_0400, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'd0, 1'b0, 1'b0, SRC, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        aQ.delete();
        rspQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0000_010C, 32'd0, 4'h0);
        serveBeat(0, 0, 1'b0, 3'd1, 32'h600D_600D, 1'b0, 1'b0, SRC, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("rsp_queue_drained", rspQ.size(), 0);
        checkOutput("a_queue_drained", aQ.size(), 0);
        checkOutput("final_idle", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tl_ul_master.md
# tl_ul_master

TileLink-UL initiator that turns simple cache-side requests (single-word load/store or multi-beat line refill) into channel-A Get/PutFullData/PutPartialData messages and collects channel-D responses. It is the requester-side counterpart of the SRAM responder: each cache (Icache, Dcache) instantiates one toward its Bus_*_a/d port pair. It allows one outstanding transaction and issues refills as a sequence of wrapping single-beat Gets.

## Interface
- SOURCE_ID, 5'd0: value driven on Bus_aBitsSource; D beats whose source differs are errors.
- LINE_WORDS, 4: words per refill; power of two, 2..16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cache request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_burst  in  1  load only: 1 = LINE_WORDS-beat refill, 0 = single word. Ignored when req_we = 1.
- req_addr  in  32  byte address; bits [1:0] ignored (forced to 0 on bus).
- req_wdata  in  32  store data.
- req_mask  in  4  store byte mask.
- rsp_valid  out  1  one-cycle pulse per completed beat; no backpressure.
- rsp_data  out  32  read data (0 for stores).
- rsp_last  out  1  final beat of the transaction.
- rsp_err  out  1  beat denied, corrupt, wrong opcode or wrong source.
- busy  out  1  high whenever state != IDLE.
- Bus_aBitsReady  in  1; Bus_aBitsValid  out  1; Bus_aBitsAddress  out  32; Bus_aBitsOpcode  out  3; Bus_aBitsSize  out  4; Bus_aBitsMask  out  4; Bus_aBitsData  out  32; Bus_aBitsParam  out  3; Bus_aBitsSource  out  5; Bus_aBitsCorrupt  out  1.
- Bus_dBitsReady  out  1; Bus_dBitsValid  in  1; Bus_dBitsOpcode  in  3; Bus_dBitsData  in  32; Bus_dBitsParam  in  2; Bus_dBitsSource  in  5; Bus_dBitsSink  in  2; Bus_dBitsDennied  in  1; Bus_dBitsCorrupt  in  1; Bus_dBitsSize  in  4.

## Operation
- States: IDLE, A_SEND, D_WAIT.
- IDLE: req_ready = 1. On req_valid, latch request, beat counter = 0, total = (req_burst & ~req_we) ? LINE_WORDS : 1, go A_SEND.
- A_SEND: Bus_aBitsValid = 1, all A fields registered and stable until Bus_aBitsReady. On handshake go D_WAIT.
- A fields: Opcode = 4 (Get) for loads; 0 (PutFullData) when mask = 4'hF; otherwise 1 (PutPartialData). Size = 2. Mask = 4'hF for Get, req_mask for puts. Data = req_wdata for puts, 0 for Get. Param = 0, Corrupt = 0, Source = SOURCE_ID.
- D_WAIT: Bus_dBitsReady = 1 (0 in every other state). On D handshake, pulse rsp_valid with rsp_data = Bus_dBitsData (loads) or 0 (stores).
- Expected D opcode: 1 (AccessAckData) for Get, 0 (AccessAck) for puts. rsp_err = Dennied | Corrupt | opcode mismatch | source != SOURCE_ID.
- Refill address: beat k address = {line base, (start_word + k) mod LINE_WORDS, 2'b00}, giving critical-word-first wrap inside the line. Only the word-index field changes; upper bits stay constant.
- After a beat: if rsp_err or k+1 == total, assert rsp_last and go IDLE. Otherwise go A_SEND with the next address.
- An error aborts the remaining refill beats.
- D beats arriving outside D_WAIT are not accepted (dReady = 0).

## Timing
- Reset (async, immediate): state IDLE, Bus_aBitsValid 0, Bus_dBitsReady 0, rsp_valid/rsp_last/rsp_err 0, rsp_data 0, busy 0, all A payload registers 0. req_ready is 1 after reset.
- Request accepted in cycle T → Bus_aBitsValid high from T+1.
- A handshake in cycle T → Bus_dBitsReady high from T+1.
- D handshake in cycle T → rsp_valid at T+1 (registered), together with either Bus_aBitsValid for the next beat or req_ready = 1.
- Minimum single transaction, with zero-wait responder: 3 cycles from accept to rsp_valid.
- A new request can be accepted in the same cycle rsp_last is asserted.
- Reset mid-transaction: any in-flight beat is abandoned and no rsp_valid is produced; the responder is expected to be reset together with this block.

## Test plan
- Single load, addr 0x0000_0104, D returns opcode 1, data 0xDEADBEEF → one A Get (addr 0x104, size 2, mask F), then rsp_valid with data 0xDEADBEEF, rsp_last = 1, rsp_err = 0.
- Refill, LINE_WORDS = 4, addr 0x208 → A addresses 0x208, 0x20C, 0x200, 0x204 in order; four rsp_valid pulses, rsp_last only on the 4th.
- Store, mask 4'h3, data 0x1234_5678 → A opcode 1, mask 3, data 0x12345678; D AccessAck → rsp_valid, rsp_data 0, rsp_last = 1.
- Backpressure: aReady held low 5 cycles, then D delayed 3 cycles → A fields stable throughout, exactly one A handshake, no response accepted early.
- Refill where beat 2 returns Dennied = 1 → rsp_err = 1 and rsp_last = 1 on beat 2; no third A request; req_ready = 1 next cycle.
- Reset asserted while in D_WAIT → all outputs at reset values immediately; a subsequent load completes normally.
